// File: rtl/mp3_play_ctrl.sv
// MP3 player sequencer: buttons and end-of-song events drive song index, play/pause and volume.
// Optional build macro MP3_REPEAT_ONE_EN: end-of-song restarts the current song instead of advancing.
//
// state     | meaning
// ST_PAUSE  | playback paused, end-of-song ignored
// ST_PLAY   | playing current song
// ST_SWITCH | o_sw_req handshake with decoder for new index, retried on timeout
module mp3_play_ctrl #(
   parameter int NUM_SONGS  = 4,
   parameter int IDX_W      = 2,
   parameter int VOL_INIT   = 8,
   parameter int ATT_STEP   = 8,
   parameter int SW_TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_next,
   input  logic             i_pre,
   input  logic             i_pause,
   input  logic             i_vol_plus,
   input  logic             i_vol_dec,
   input  logic             i_finish_song,
   input  logic             i_sw_ack,
   output logic [IDX_W-1:0] o_song_idx,
   output logic             o_pause,
   output logic [3:0]       o_vol_level,
   output logic [7:0]       o_vol_att,
   output logic             o_sw_req,
   output logic             o_disp_upd,
   output logic [3:0]       o_retry_cnt
);

   localparam int               TMO_W    = $clog2(SW_TIMEOUT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SONGS - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(SW_TIMEOUT - 1);
   localparam logic [3:0]       VOL_RST  = 4'(VOL_INIT);
   localparam logic [7:0]       ATT_RST  = 8'((15 - VOL_INIT) * ATT_STEP);

   typedef enum logic [1:0] {ST_PAUSE, ST_PLAY, ST_SWITCH} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_inc, idx_dec, idx_fin, tgt;
   logic [3:0]       vol_q, vol_d;
   logic [7:0]       att_q, att_d;
   logic [15:0]      att_full;
   logic             pause_q, pause_d;
   logic             req_q, req_d;
   logic             disp_q, disp_d;
   logic [3:0]       retry_q, retry_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             go_sw;

   assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
   assign idx_dec = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
`ifdef MP3_REPEAT_ONE_EN
   assign idx_fin = idx_q;
`else
   assign idx_fin = idx_inc;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      req_d   = req_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      vol_d   = vol_q;
      go_sw   = 1'b0;
      tgt     = idx_q;

      case (state_q)
         ST_PLAY: begin
            if (i_finish_song) begin
               go_sw = 1'b1;
               tgt   = idx_fin;
            end else if (i_next) begin
               go_sw = 1'b1;
               tgt   = idx_inc;
            end else if (i_pre) begin
               go_sw = 1'b1;
               tgt   = idx_dec;
            end else if (i_pause) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (i_next) begin
               go_sw = 1'b1;
               tgt   = idx_inc;
            end else if (i_pre) begin
               go_sw = 1'b1;
               tgt   = idx_dec;
            end else if (i_pause) begin
               state_d = ST_PLAY;
            end
         end
         ST_SWITCH: begin
            // button pulses are intentionally dropped while the decoder switches
            if (i_sw_ack) begin
               req_d   = 1'b0;
               state_d = ST_PLAY;
            end else if (!req_q) begin
               req_d = 1'b1;
               tmo_d = TMO_LOAD;
            end else if (tmo_q == '0) begin
               req_d = 1'b0;
               if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         default: state_d = ST_PAUSE;
      endcase

      if (go_sw) begin
         state_d = ST_SWITCH;
         idx_d   = tgt;
         req_d   = 1'b1;
         tmo_d   = TMO_LOAD;
      end

      if (i_vol_plus && !i_vol_dec && vol_q != 4'hF) begin
         vol_d = vol_q + 4'd1;
      end else if (i_vol_dec && !i_vol_plus && vol_q != 4'h0) begin
         vol_d = vol_q - 4'd1;
      end

      att_full = {12'd0, 4'hF - vol_d} * 16'(ATT_STEP);
      att_d    = att_full[7:0];
      pause_d  = (state_d == ST_PAUSE);
      disp_d   = (idx_d != idx_q) || (pause_d != pause_q) || (vol_d != vol_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_PAUSE;
         idx_q   <= '0;
         pause_q <= 1'b1;
         vol_q   <= VOL_RST;
         att_q   <= ATT_RST;
         req_q   <= 1'b0;
         disp_q  <= 1'b0;
         retry_q <= 4'd0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pause_q <= pause_d;
         vol_q   <= vol_d;
         att_q   <= att_d;
         req_q   <= req_d;
         disp_q  <= disp_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
      end
   end

   assign o_song_idx  = idx_q;
   assign o_pause     = pause_q;
   assign o_vol_level = vol_q;
   assign o_vol_att   = att_q;
   assign o_sw_req    = req_q;
   assign o_disp_upd  = disp_q;
   assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// Bench for mp3_play_ctrl: directed scenarios then random button traffic against a behavioural player model.
module tb_mp3_play_ctrl;

   localparam int N     = 4;
   localparam int TO    = 10;
   localparam int VINIT = 8;
   localparam int STEP  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_next = 1'b0, i_pre = 1'b0, i_pause = 1'b0;
   logic       i_vol_plus = 1'b0, i_vol_dec = 1'b0;
   logic       i_finish_song = 1'b0, i_sw_ack = 1'b0;
   logic [1:0] o_song_idx;
   logic       o_pause, o_sw_req, o_disp_upd;
   logic [3:0] o_vol_level, o_retry_cnt;
   logic [7:0] o_vol_att;

   mp3_play_ctrl #(
      .NUM_SONGS(N), .IDX_W(2), .VOL_INIT(VINIT), .ATT_STEP(STEP), .SW_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_next(i_next), .i_pre(i_pre), .i_pause(i_pause),
      .i_vol_plus(i_vol_plus), .i_vol_dec(i_vol_dec),
      .i_finish_song(i_finish_song), .i_sw_ack(i_sw_ack),
      .o_song_idx(o_song_idx), .o_pause(o_pause),
      .o_vol_level(o_vol_level), .o_vol_att(o_vol_att),
      .o_sw_req(o_sw_req), .o_disp_upd(o_disp_upd), .o_retry_cnt(o_retry_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   int disp_seen = 0;

   // player model: mode 0 = paused, 1 = playing, 2 = switching song
   int m_mode, m_idx, m_vol, m_retry, m_hi;
   bit m_req, m_disp;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_vol = VINIT; m_retry = 0; m_hi = 0;
      m_req = 0; m_disp = 0;
   endtask

   task automatic start_switch(input int target);
      m_idx = target; m_mode = 2; m_req = 1; m_hi = 1;
   endtask

   task automatic model_edge(input bit rst, nx, pr, pa, vp, vd, fin, ack);
      int  o_idx, o_vol;
      bit  o_paused;
      o_idx = m_idx; o_vol = m_vol; o_paused = (m_mode == 0);
      if (!rst) begin
         model_reset();
         return;
      end
      if (m_mode == 1) begin
`ifdef MP3_REPEAT_ONE_EN
         if (fin) start_switch(m_idx);
`else
         if (fin) start_switch((m_idx + 1) % N);
`endif
         else if (nx) start_switch((m_idx + 1) % N);
         else if (pr) start_switch((m_idx + N - 1) % N);
         else if (pa) m_mode = 0;
      end else if (m_mode == 0) begin
         if (nx) start_switch((m_idx + 1) % N);
         else if (pr) start_switch((m_idx + N - 1) % N);
         else if (pa) m_mode = 1;
      end else begin
         if (ack) begin
            m_req = 0; m_mode = 1;
         end else if (!m_req) begin
            m_req = 1; m_hi = 1;
         end else if (m_hi == TO) begin
            m_req = 0;
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
         end else begin
            m_hi++;
         end
      end
      if (vp && !vd) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
      if (vd && !vp) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      m_disp = (m_idx != o_idx) || (m_vol != o_vol) || ((m_mode == 0) != o_paused);
   endtask

   task automatic check_all();
      chk("song_idx", 16'(o_song_idx), 16'(m_idx));
      chk("pause", 16'(o_pause), 16'(m_mode == 0));
      chk("vol_level", 16'(o_vol_level), 16'(m_vol));
      chk("vol_att", 16'(o_vol_att), 16'(((15 - m_vol) * STEP) % 256));
      chk("sw_req", 16'(o_sw_req), 16'(m_req));
      chk("disp_upd", 16'(o_disp_upd), 16'(m_disp));
      chk("retry_cnt", 16'(o_retry_cnt), 16'(m_retry));
      if (o_disp_upd === 1'b1) disp_seen++;
   endtask

   task automatic step(input bit rst, nx, pr, pa, vp, vd, fin, ack);
      @(negedge clk);
      rst_n = rst; i_next = nx; i_pre = pr; i_pause = pa;
      i_vol_plus = vp; i_vol_dec = vd; i_finish_song = fin; i_sw_ack = ack;
      model_edge(rst, nx, pr, pa, vp, vd, fin, ack);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      // reset and first play
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      chk("play_pause", 16'(o_pause), 16'd0);
      chk("play_att", 16'(o_vol_att), 16'd56);
      chk("play_disp", 16'(o_disp_upd), 16'd1);
      idle(1);
      chk("play_disp_once", 16'(o_disp_upd), 16'd0);

      // move to idx 3, then end-of-song at the last song
      step(1, 0, 1, 0, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      chk("pre_wrap_idx", 16'(o_song_idx), 16'd3);
      step(1, 0, 0, 0, 0, 0, 1, 0);
`ifdef MP3_REPEAT_ONE_EN
      chk("finish_idx", 16'(o_song_idx), 16'd3);
`else
      chk("finish_idx", 16'(o_song_idx), 16'd0);
`endif
      chk("finish_req", 16'(o_sw_req), 16'd1);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      chk("ack_req_low", 16'(o_sw_req), 16'd0);
      idle(1);

      // next and pre together, then pre dropped during switch
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      chk("idx_after_drop", 16'(o_song_idx), 16'(m_idx));

      // ack outside switch is ignored
      step(1, 0, 0, 0, 0, 0, 0, 1);

      // never acked: retries until the counter saturates
      step(1, 1, 0, 0, 0, 0, 0, 0);
      idle(17 * (TO + 1));
      chk("retry_sat", 16'(o_retry_cnt), 16'd15);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);

      // volume saturation and redraw count
      disp_seen = 0;
      for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 1, 0, 0, 0);
      idle(1);
      chk("vol_up_pulses", 16'(disp_seen), 16'd7);
      chk("vol_max", 16'(o_vol_level), 16'd15);
      chk("att_min", 16'(o_vol_att), 16'd0);
      step(1, 0, 0, 0, 1, 1, 0, 0);
      chk("vol_both", 16'(o_vol_level), 16'd15);
      for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 0, 1, 0, 0);
      chk("vol_min", 16'(o_vol_level), 16'd0);
      chk("att_max", 16'(o_vol_att), 16'd120);

      // reset while requesting a switch
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_req", 16'(o_sw_req), 16'd0);
      chk("rst_vol", 16'(o_vol_level), 16'd8);
      idle(1);

      // random button traffic
      for (int k = 0; k < 600; k++) begin
         bit r, nx, pr, pa, vp, vd, fin, ack;
         r   = ($urandom_range(0, 199) != 0);
         nx  = ($urandom_range(0, 9) == 0);
         pr  = ($urandom_range(0, 9) == 0);
         pa  = ($urandom_range(0, 7) == 0);
         vp  = ($urandom_range(0, 4) == 0);
         vd  = ($urandom_range(0, 4) == 0);
         fin = ($urandom_range(0, 11) == 0);
         ack = m_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
         step(r, nx, pr, pa, vp, vd, fin, ack);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
